sr_imem_loader: RTL and testbench

Instruction memory with a built-in program loader; sits directly upstream of the CPU core. It receives a program as a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. It stores those words in an internal word-addressed RAM, then serves them on the core's combinational instruction-fetch port (`imAddr`/`imData`). It also holds the core in reset (`cpuRstN`) until a complete program has been loaded.

---
 rtl/sr_imem_loader.sv | 155 +++++++++++++++
 tb/tb_sr_imem_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_imem_loader.sv
// Instruction memory with built-in byte-stream program loader.
// Packs a little-endian byte stream (16-bit word-count header followed by
// N 32-bit words) into a word RAM. Holds the core in reset until the
// program is complete, then serves combinational instruction fetches.
module sr_imem_loader #(
  parameter int unsigned WORD_ADDR_W = 6,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imAddr,
  output logic [31:0] imData,
  input  logic        loadStart,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        cpuRstN,
  output logic        busy,
  output logic        error
);

  localparam int unsigned DEPTH   = 1 << WORD_ADDR_W;
  localparam logic [16:0] L_DEPTH = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    RUN,
    ERR
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [15:0]          r_n;
  logic [1:0]           r_lane;
  logic [WORD_ADDR_W:0] r_waddr;
  logic [23:0]          r_wbuf;
  logic                 r_cpu_rst_n;
  logic [31:0]          r_mem [DEPTH];

  logic                 w_accept;
  logic [15:0]          w_n_full;
  logic                 w_lane3;
  logic                 w_last_word;
  logic                 w_wr_en;
  logic                 w_in_range;

  assign w_accept    = byteValid & byteReady;
  assign w_n_full    = {byteData, r_n[7:0]};
  assign w_lane3     = (r_lane == 2'd3);
  // Address counter is one bit wider than the RAM index so N == DEPTH
  // terminates on word DEPTH-1 without wrapping to zero.
  assign w_last_word = ({1'b0, r_n} == (17'(r_waddr) + 17'd1));
  assign w_wr_en     = (r_state == DATA) & w_accept & w_lane3;
  assign w_in_range  = (imAddr[31:WORD_ADDR_W] == '0) && (imAddr < 32'(r_n));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; loadStart overrides every state
  always_comb begin
    w_next = r_state;
    if (loadStart) begin
      w_next = HDR0;
    end else begin
      case (r_state)
        HDR0: if (w_accept) w_next = HDR1;
        HDR1: begin
          if (w_accept) begin
            if (w_n_full == 16'd0)                 w_next = RUN;
            else if ({1'b0, w_n_full} > L_DEPTH)   w_next = ERR;
            else                                   w_next = DATA;
          end
        end
        DATA: if (w_accept && w_lane3 && w_last_word) w_next = RUN;
        default: w_next = r_state;
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy      = 1'b0;
    error     = 1'b0;
    byteReady = 1'b0;
    case (r_state)
      HDR0, HDR1, DATA: busy  = 1'b1;
      ERR:              error = 1'b1;
      default: ;
    endcase
    byteReady = busy & ~loadStart;
  end

  // Header capture, byte-lane packing, word address and core reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n         <= '0;
      r_lane      <= '0;
      r_waddr     <= '0;
      r_wbuf      <= '0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_next == RUN);
      if (loadStart) begin
        r_lane  <= '0;
        r_waddr <= '0;
      end else if (w_accept) begin
        case (r_state)
          HDR0: r_n[7:0] <= byteData;
          HDR1: begin
            r_n[15:8] <= byteData;
            r_lane    <= '0;
            r_waddr   <= '0;
          end
          DATA: begin
            case (r_lane)
              2'd0: r_wbuf[7:0]   <= byteData;
              2'd1: r_wbuf[15:8]  <= byteData;
              2'd2: r_wbuf[23:16] <= byteData;
              default: r_waddr    <= r_waddr + 1'b1;
            endcase
            r_lane <= r_lane + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Program RAM; never cleared, survives reset and aborted loads
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_waddr[WORD_ADDR_W-1:0]] <= {byteData, r_wbuf};
    end
  end

  // Combinational fetch port
  always_comb begin
    imData = NOP_WORD;
    if ((r_state == RUN) && w_in_range) begin
      imData = r_mem[imAddr[WORD_ADDR_W-1:0]];
    end
  end

  assign cpuRstN = r_cpu_rst_n;

endmodule

// File: tb/tb_sr_imem_loader.sv
module tb_sr_imem_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  localparam int unsigned SEL_IMDATA = 0;
  localparam int unsigned SEL_RSTN   = 1;
  localparam int unsigned SEL_BUSY   = 2;
  localparam int unsigned SEL_ERROR  = 3;
  localparam int unsigned SEL_READY  = 4;
  localparam int unsigned SEL_ACC    = 5;

  typedef struct {
    int unsigned sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        loadStart;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic        cpuRstN;
  logic        busy;
  logic        error;

  chk_t        sb[$];
  event        ev_chk;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_acc    = 0;
  int unsigned acc_base = 0;

  sr_imem_loader #(
    .WORD_ADDR_W (6),
    .NOP_WORD    (32'h00000013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imAddr    (imAddr),
    .imData    (imData),
    .loadStart (loadStart),
    .byteData  (byteData),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .cpuRstN   (cpuRstN),
    .busy      (busy),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && byteValid && byteReady) n_acc <= n_acc + 1;
  end

  always @(ev_chk) begin
    while (sb.size() > 0) begin
      chk_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        SEL_IMDATA: act = imData;
        SEL_RSTN:   act = {31'd0, cpuRstN};
        SEL_BUSY:   act = {31'd0, busy};
        SEL_ERROR:  act = {31'd0, error};
        SEL_READY:  act = {31'd0, byteReady};
        default:    act = n_acc - acc_base;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input int unsigned sel, input logic [31:0] exp, input string name);
    chk_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk();
    #1 -> ev_chk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start();
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string name);
    imAddr = a;
    expect_v(SEL_IMDATA, exp, name);
    chk();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned k;
    k = 0;
    byteData  = b;
    byteValid = 1'b1;
    #1;
    while (!byteReady && k < 20) begin
      tick();
      k++;
    end
    if (!byteReady) begin
      expect_v(SEL_READY, 32'd1, "byte_ready_timeout");
      chk();
    end else begin
      tick();
    end
  endtask

  task automatic send_prog(input logic [7:0] bytes[$], input bit gap, input logic rst_after);
    int unsigned last;
    last = bytes.size() - 1;
    acc_base = n_acc;
    for (int unsigned i = 0; i <= last; i++) begin
      if (i == last) begin
        expect_v(SEL_RSTN, 32'd0, "rstn_before_last");
        chk();
      end
      send_byte(bytes[i]);
      if (i == last) begin
        expect_v(SEL_RSTN, {31'd0, rst_after}, "rstn_after_last");
        chk();
      end
      if (gap) begin
        byteValid = 1'b0;
        tick();
        if (i != last) begin
          expect_v(SEL_BUSY, 32'd1, "busy_during_stall");
          chk();
        end
      end
    end
    byteValid = 1'b0;
    expect_v(SEL_ACC, bytes.size(), "bytes_accepted");
    chk();
  endtask

  function automatic logic [31:0] word_pat(input int unsigned w);
    logic [7:0] lo;
    lo = 8'(w);
    return {8'hA5, lo, 8'h5A, ~lo};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog2[$];
    logic [7:0] big[$];
    logic [31:0] w;

    prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    rst_n = 1'b0; loadStart = 1'b0; byteData = '0; byteValid = 1'b0; imAddr = '0;
    expect_v(SEL_RSTN, 32'd0, "reset_cpurstn");
    expect_v(SEL_BUSY, 32'd0, "reset_busy");
    expect_v(SEL_ERROR, 32'd0, "reset_error");
    expect_v(SEL_READY, 32'd0, "reset_ready");
    expect_v(SEL_IMDATA, NOP, "reset_imdata");
    chk();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    load_start();
    expect_v(SEL_BUSY, 32'd1, "t1_busy");
    chk();
    send_prog(prog2, 1'b0, 1'b1);
    fetch(32'd0, 32'h00100513, "t1_word0");
    fetch(32'd1, 32'h00200593, "t1_word1");
    fetch(32'd2, NOP, "t1_word2_unloaded");
    fetch(32'd64, NOP, "t1_upper_bits");
    imAddr = 32'd0;
    #1;
    n_checks++;
    if (imData !== 32'h00100513) begin
      n_fail++;
      $display("FAIL t1_direct_word0: got %h expected %h", imData, 32'h00100513);
    end

    load_start();
    expect_v(SEL_RSTN, 32'd0, "t2_rstn_fall");
    chk();
    send_prog(prog2, 1'b1, 1'b1);
    fetch(32'd0, 32'h00100513, "t2_word0");
    fetch(32'd1, 32'h00200593, "t2_word1");
    fetch(32'd2, NOP, "t2_word2_unloaded");

    big = '{8'h40, 8'h00};
    for (int unsigned i = 0; i < 64; i++) begin
      w = word_pat(i);
      big.push_back(w[7:0]);
      big.push_back(w[15:8]);
      big.push_back(w[23:16]);
      big.push_back(w[31:24]);
    end
    load_start();
    send_prog(big, 1'b0, 1'b1);
    fetch(32'd0, word_pat(0), "t3_word0");
    fetch(32'd31, word_pat(31), "t3_word31");
    fetch(32'd63, word_pat(63), "t3_word63");
    fetch(32'd64, NOP, "t3_word64");

    load_start();
    send_prog('{8'h41, 8'h00}, 1'b0, 1'b0);
    expect_v(SEL_ERROR, 32'd1, "t4_error");
    expect_v(SEL_BUSY, 32'd0, "t4_busy");
    chk();
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_direct_error: got %b expected %b", error, 1'b1);
    end
    acc_base = n_acc;
    byteData = 8'h77; byteValid = 1'b1;
    expect_v(SEL_READY, 32'd0, "t4_ready");
    chk();
    tick(); tick();
    expect_v(SEL_ACC, 32'd0, "t4_no_accept");
    expect_v(SEL_RSTN, 32'd0, "t4_rstn");
    chk();
    fetch(32'd0, NOP, "t4_imdata");
    byteValid = 1'b0;
    load_start();
    expect_v(SEL_ERROR, 32'd0, "t4_error_clear");
    expect_v(SEL_BUSY, 32'd1, "t4_busy_again");
    chk();

    send_prog('{8'h00, 8'h00}, 1'b0, 1'b1);
    fetch(32'd0, NOP, "t5_addr0");
    fetch(32'd1, NOP, "t5_addr1");
    fetch(32'd63, NOP, "t5_addr63");

    load_start();
    send_prog('{8'h01, 8'h00, 8'hAA, 8'hBB}, 1'b0, 1'b0);
    acc_base = n_acc;
    loadStart = 1'b1; byteValid = 1'b1; byteData = 8'hCC;
    expect_v(SEL_READY, 32'd0, "t6_ready_collide");
    chk();
    tick();
    loadStart = 1'b0; byteValid = 1'b0;
    expect_v(SEL_ACC, 32'd0, "t6_not_accepted");
    expect_v(SEL_BUSY, 32'd1, "t6_busy");
    expect_v(SEL_RSTN, 32'd0, "t6_rstn");
    chk();
    send_prog('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0, 1'b1);
    fetch(32'd0, 32'hDEADBEEF, "t6_word0");
    fetch(32'd1, NOP, "t6_word1_outside_n");
    imAddr = 32'd0;
    #1;
    n_checks++;
    if (imData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL t6_direct_word0: got %h expected %h", imData, 32'hDEADBEEF);
    end

    load_start();
    send_prog('{8'h02, 8'h00, 8'h11, 8'h22}, 1'b0, 1'b0);
    rst_n = 1'b0;
    expect_v(SEL_BUSY, 32'd0, "t7_busy_async");
    expect_v(SEL_RSTN, 32'd0, "t7_rstn_async");
    expect_v(SEL_READY, 32'd0, "t7_ready_async");
    chk();
    tick();
    rst_n = 1'b1;
    tick();
    load_start();
    send_prog(prog2, 1'b0, 1'b1);
    fetch(32'd0, 32'h00100513, "t7_word0");
    fetch(32'd1, 32'h00200593, "t7_word1");
    rst_n = 1'b0;
    expect_v(SEL_RSTN, 32'd0, "t7_run_rstn_async");
    expect_v(SEL_IMDATA, NOP, "t7_run_imdata_async");
    chk();
    tick();
    rst_n = 1'b1;
    tick();

    #1 -> ev_chk;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
